// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: register-dependency and mult/div-busy stall generation for the E-stage register.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  Tuse_rs,
    input  logic [1:0]  Tuse_rt,
    input  logic [4:0]  waddr_E,
    input  logic [1:0]  Tnew_E,
    input  logic [4:0]  waddr_M,
    input  logic [1:0]  Tnew_M,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use_D,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;

    // Tnew never exceeds 2, so Tuse=3 (source unused) can never trigger a stall.
    always_comb begin
        stall_rs = (rs_D != 5'd0) &&
                   (((rs_D == waddr_E) && (Tnew_E > Tuse_rs)) ||
                    ((rs_D == waddr_M) && (Tnew_M > Tuse_rs)));
        stall_rt = (rt_D != 5'd0) &&
                   (((rt_D == waddr_E) && (Tnew_E > Tuse_rt)) ||
                    ((rt_D == waddr_M) && (Tnew_M > Tuse_rt)));
        stall_md = md_use_D && (md_start || md_busy);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign md_busy = (cnt_q != 4'd0);

    // A new md_start while busy is ignored: the issuing instruction is held in D.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (md_start) begin
            cnt_d = md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed per-cycle vectors push expectations, a negedge monitor checks them.
// Stall-count expectations follow HAZARD_STATS_EN when the bench is compiled with that macro.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs_D = '0;
    logic [4:0]  rt_D = '0;
    logic [1:0]  Tuse_rs = 2'd3;
    logic [1:0]  Tuse_rt = 2'd3;
    logic [4:0]  waddr_E = '0;
    logic [1:0]  Tnew_E = '0;
    logic [4:0]  waddr_M = '0;
    logic [1:0]  Tnew_M = '0;
    logic        md_start = 1'b0;
    logic        md_is_div = 1'b0;
    logic        md_use_D = 1'b0;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;

    typedef struct {
        logic       rstn;
        logic [4:0] rs;
        logic [1:0] tur;
        logic [4:0] rt;
        logic [1:0] tut;
        logic [4:0] we;
        logic [1:0] tne;
        logic [4:0] wm;
        logic [1:0] tnm;
        logic       st;
        logic       dv;
        logic       use_md;
        logic       eStall;
        logic       eBusy;
        string      name;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     modelCnt = 0;
`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .waddr_E(waddr_E), .Tnew_E(Tnew_E), .waddr_M(waddr_M), .Tnew_M(Tnew_M),
        .md_start(md_start), .md_is_div(md_is_div), .md_use_D(md_use_D),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rstn,
                                input logic [4:0] rs, input logic [1:0] tur,
                                input logic [4:0] rt, input logic [1:0] tut,
                                input logic [4:0] we, input logic [1:0] tne,
                                input logic [4:0] wm, input logic [1:0] tnm,
                                input logic st, input logic dv, input logic use_md,
                                input logic eStall, input logic eBusy, input string name);
        vec_t v;
        v.rstn = rstn; v.rs = rs; v.tur = tur; v.rt = rt; v.tut = tut;
        v.we = we; v.tne = tne; v.wm = wm; v.tnm = tnm;
        v.st = st; v.dv = dv; v.use_md = use_md;
        v.eStall = eStall; v.eBusy = eBusy; v.name = name;
        return v;
    endfunction

    // Inputs change just after the rising edge; the expected response for that cycle is queued.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset = v.rstn; rs_D = v.rs; Tuse_rs = v.tur; rt_D = v.rt; Tuse_rt = v.tut;
        waddr_E = v.we; Tnew_E = v.tne; waddr_M = v.wm; Tnew_M = v.tnm;
        md_start = v.st; md_is_div = v.dv; md_use_D = v.use_md;
        if (!v.rstn) modelCnt = 0;
        e.stall = v.eStall;
        e.busy  = v.eBusy;
        e.cnt   = STATS_EN ? 32'(modelCnt) : 32'd0;
        e.name  = v.name;
        sb.push_back(e);
        if (v.rstn && v.eStall) modelCnt++;
    endtask

    task automatic checkOutput(input string name, input string what,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, what, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.name, "stall",     32'(stall),   32'(e.stall));
            checkOutput(e.name, "md_busy",   32'(md_busy), 32'(e.busy));
            checkOutput(e.name, "stall_cnt", stall_cnt,    e.cnt);
        end
    end

    initial begin
        applyStimulus(mk(0, 0,3,0,3, 0,0,0,0, 0,0,0, 0,0, "reset"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,0, 0,0, "idle"));
        applyStimulus(mk(1, 5,1,0,3, 5,2,0,0, 0,0,0, 1,0, "loaduse_E"));
        applyStimulus(mk(1, 5,1,0,3, 0,0,5,1, 0,0,0, 0,0, "loaduse_M"));
        applyStimulus(mk(1, 0,0,0,3, 0,2,0,0, 0,0,0, 0,0, "reg0"));
        applyStimulus(mk(1, 0,3,7,3, 7,2,0,0, 0,0,0, 0,0, "tuse3"));
        applyStimulus(mk(1, 0,3,9,0, 0,0,9,1, 0,0,0, 1,0, "rt_M"));
        applyStimulus(mk(1, 3,0,0,3, 3,1,3,1, 0,0,0, 1,0, "rs_EM"));
        applyStimulus(mk(1, 3,1,0,3, 3,1,3,1, 0,0,0, 0,0, "tnew_eq_tuse"));

        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 1,0,1, 1,0, "mult_issue"));
        for (int i = 0; i < 5; i++)
            applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,1, 1,1, "mult_busy"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,1, 0,0, "mult_done"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,0, 0,0, "idle2"));

        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 1,1,0, 0,0, "div_issue"));
        for (int i = 1; i <= 10; i++)
            applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, logic'(i == 3),1,logic'(i == 5),
                             logic'(i == 5),1, "div_busy"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,1, 0,0, "div_done"));

        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 1,1,0, 0,0, "div2_issue"));
        for (int i = 0; i < 3; i++)
            applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,0, 0,1, "div2_busy"));
        applyStimulus(mk(0, 0,3,0,3, 0,0,0,0, 0,0,1, 0,0, "reset_middiv"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,1, 0,0, "after_reset"));

        applyStimulus(mk(1, 4,0,0,3, 4,2,0,0, 1,0,1, 1,0, "overlap_issue"));
        applyStimulus(mk(1, 4,0,0,3, 4,2,0,0, 0,0,1, 1,1, "overlap_busy"));
        applyStimulus(mk(1, 0,3,0,3, 0,0,0,0, 0,0,0, 0,1, "busy_no_use"));
        applyStimulus(mk(0, 0,3,0,3, 0,0,0,0, 0,0,0, 0,0, "final_reset"));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
